mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_sram_strobe_gen.sv | 23 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter: FSM state encoding,
// requester tag, SRAM strobe bundle with its idle value, and default widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
  } strobe_t;

  localparam strobe_t STROBE_OFF = '{en_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU stages, the arbiter and the board SRAM pins.
// The slave modport is the arbiter's view; master is the CPU/SRAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              if_req;
  logic [15:0]       if_addr;
  logic [15:0]       if_inst;
  logic              if_done;

  logic              mem_rd;
  logic              mem_wr;
  logic [15:0]       mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_done;
  logic              mem_conflict;

  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic              ram_en_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
    output if_inst, if_done, mem_rdata, mem_done, mem_conflict,
           ram_addr, ram_wdata, ram_en_n, ram_oe_n, ram_we_n
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
    input  if_inst, if_done, mem_rdata, mem_done, mem_conflict,
           ram_addr, ram_wdata, ram_en_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/mem_arbiter_sram_strobe_gen.sv
// Decodes the arbiter state into active-low SRAM strobes. Output enable is
// only ever asserted in RD and write enable only in WR_PULSE, so the two can
// never overlap; every other state parks the SRAM with all strobes high.
module sram_strobe_gen
  import mem_arbiter_pkg::*;
(
  input  state_t  state,
  output strobe_t strobe
);

  // Pure state decode, idle strobes unless the state says otherwise
  always_comb begin
    strobe = STROBE_OFF;
    case (state)
      ST_RD:       strobe = '{en_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
      ST_WR_SETUP: strobe = '{en_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
      ST_WR_PULSE: strobe = '{en_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};
      ST_WR_HOLD:  strobe = '{en_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
      default:     strobe = STROBE_OFF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch and the MEM stage.
// Data accesses win over fetch; a read takes one RD cycle, a write runs
// setup/pulse/hold. Address and store data are latched at grant.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a fetch grant
// after STARVE_MAX consecutive data grants while a fetch is waiting.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  src_t              src;
  logic              grant_if;
  logic              grant_mem_rd;
  logic              grant_wr;
  logic              force_fetch;
  logic              forced_rd;
  logic              data_busy;
  logic              fetch_forced;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [15:0]       ram_wdata_q;
  logic [15:0]       if_inst_q;
  logic [15:0]       mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;
  strobe_t           strobe;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign force_fetch = bus.if_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Count data grants made while a fetch is waiting; any fetch grant clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_mem_rd || grant_wr) begin
      if (!bus.if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_starve_max;

  assign unused_starve_max = (STARVE_MAX > 0);
  assign force_fetch       = 1'b0;
`endif

  // State register; reset drops straight to IDLE so strobes release at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration in IDLE and fixed sequencing through the read/write states
  always_comb begin
    state_nxt    = state;
    grant_if     = 1'b0;
    grant_mem_rd = 1'b0;
    grant_wr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (force_fetch) begin
          grant_if  = 1'b1;
          state_nxt = ST_RD;
        end else if (bus.mem_wr) begin
          grant_wr  = 1'b1;
          state_nxt = ST_WR_SETUP;
        end else if (bus.mem_rd) begin
          grant_mem_rd = 1'b1;
          state_nxt    = ST_RD;
        end else if (bus.if_req) begin
          grant_if  = 1'b1;
          state_nxt = ST_RD;
        end
      end
      ST_RD:       state_nxt = ST_IDLE;
      ST_WR_SETUP: state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Latch address/data at grant, capture read data and emit done pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src         <= SRC_IF;
      forced_rd   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (grant_if || grant_mem_rd || grant_wr) begin
        ram_addr_q <= grant_if ? ADDR_W'(bus.if_addr) : ADDR_W'(bus.mem_addr);
        src        <= grant_if ? SRC_IF : SRC_MEM;
        forced_rd  <= grant_if && force_fetch;
      end
      if (grant_wr) begin
        ram_wdata_q <= bus.mem_wdata;
      end
      if (state == ST_RD) begin
        if (src == SRC_MEM) begin
          mem_rdata_q <= bus.ram_rdata;
          mem_done_q  <= 1'b1;
        end else begin
          if_inst_q <= bus.ram_rdata;
          if_done_q <= 1'b1;
        end
      end
      if (state == ST_WR_HOLD) begin
        mem_done_q <= 1'b1;
      end
    end
  end

  sram_strobe_gen u_strobe (
    .state  (state),
    .strobe (strobe)
  );

  assign data_busy = ((state == ST_RD) && (src == SRC_MEM)) ||
                     (state == ST_WR_SETUP) ||
                     (state == ST_WR_PULSE) ||
                     (state == ST_WR_HOLD);

  assign fetch_forced = ((state == ST_IDLE) && force_fetch) ||
                        ((state == ST_RD) && forced_rd);

  assign bus.mem_conflict = (bus.mem_rd | bus.mem_wr | data_busy) & ~fetch_forced;
  assign bus.if_inst      = if_inst_q;
  assign bus.if_done      = if_done_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.ram_en_n     = strobe.en_n;
  assign bus.ram_oe_n     = strobe.oe_n;
  assign bus.ram_we_n     = strobe.we_n;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural async SRAM.
// Covers reset values, fetch, store, read-back, data/fetch conflict,
// alternating read/write strobe safety, starvation (both builds of
// MEM_ARB_STARVE_GUARD_EN) and reset in the middle of a write pulse.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   we_low_cycles;
  int   both_low_cycles;
  int   we_snap;
  int   both_snap;
  int   data_count;
  int   fetch_seen;
  logic conflict_at_fourth;

  logic [15:0] sram [0:255];

  mem_arbiter_if #(.ADDR_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W     (16),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM read path
  assign bus.ram_rdata = sram[bus.ram_addr[7:0]];

  // SRAM write and strobe monitoring, sampled mid-cycle
  always @(negedge clk) begin
    if (!bus.ram_we_n && !bus.ram_en_n) begin
      sram[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end
    if (!bus.ram_we_n) begin
      we_low_cycles <= we_low_cycles + 1;
    end
    if (!bus.ram_we_n && !bus.ram_oe_n) begin
      both_low_cycles <= both_low_cycles + 1;
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic if_req, input logic [15:0] if_addr,
                               input logic mem_rd, input logic mem_wr,
                               input logic [15:0] mem_addr, input logic [15:0] mem_wdata);
    bus.if_req    = if_req;
    bus.if_addr   = if_addr;
    bus.mem_rd    = mem_rd;
    bus.mem_wr    = mem_wr;
    bus.mem_addr  = mem_addr;
    bus.mem_wdata = mem_wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One data access with bounded wait; checks latency and read data
  task automatic doAccess(input string tag, input logic is_write,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rdata);
    int n;
    n = 0;
    applyStimulus(1'b0, 16'h0000, !is_write, is_write, addr, wdata);
    do begin
      tick();
      n++;
    end while (!bus.mem_done && n < 10);
    checkOutput({tag, "_done"}, 16'(bus.mem_done), 16'h0001);
    checkOutput({tag, "_lat"}, 16'(n), is_write ? 16'd4 : 16'd2);
    if (!is_write) begin
      checkOutput({tag, "_rdata"}, bus.mem_rdata, exp_rdata);
    end
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    we_low_cycles   = 0;
    both_low_cycles = 0;
    for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
    sram[8'h04] = 16'h4A05;
    sram[8'h10] = 16'h1234;
    sram[8'h20] = 16'hBEEF;

    // Reset values
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    checkOutput("rst_if_inst", bus.if_inst, 16'h0000);
    checkOutput("rst_mem_rdata", bus.mem_rdata, 16'h0000);
    checkOutput("rst_if_done", 16'(bus.if_done), 16'h0000);
    checkOutput("rst_mem_done", 16'(bus.mem_done), 16'h0000);
    checkOutput("rst_ram_addr", bus.ram_addr, 16'h0000);
    checkOutput("rst_ram_wdata", bus.ram_wdata, 16'h0000);
    checkOutput("rst_strobes", 16'({bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n}), 16'h0007);
    checkOutput("rst_conflict", 16'(bus.mem_conflict), 16'h0000);
    rst = 1'b1;

    // Fetch only
    applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("fetch_rd_strobes", 16'({bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n}), 16'h0001);
    checkOutput("fetch_rd_addr", bus.ram_addr, 16'h0004);
    checkOutput("fetch_rd_done", 16'(bus.if_done), 16'h0000);
    checkOutput("fetch_conflict", 16'(bus.mem_conflict), 16'h0000);
    tick();
    checkOutput("fetch_done", 16'(bus.if_done), 16'h0001);
    checkOutput("fetch_inst", bus.if_inst, 16'h4A05);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    checkOutput("fetch_done_pulse", 16'(bus.if_done), 16'h0000);

    // Store, then back-to-back read-back in the done cycle
    we_snap = we_low_cycles;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h0014);
    #1;
    checkOutput("st_conflict_req", 16'(bus.mem_conflict), 16'h0001);
    tick();
    checkOutput("st_setup_strobes", 16'({bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n}), 16'h0003);
    checkOutput("st_setup_addr", bus.ram_addr, 16'h0008);
    checkOutput("st_setup_wdata", bus.ram_wdata, 16'h0014);
    tick();
    checkOutput("st_pulse_strobes", 16'({bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n}), 16'h0002);
    tick();
    checkOutput("st_hold_strobes", 16'({bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n}), 16'h0003);
    checkOutput("st_hold_done", 16'(bus.mem_done), 16'h0000);
    checkOutput("st_hold_conflict", 16'(bus.mem_conflict), 16'h0001);
    tick();
    checkOutput("st_done", 16'(bus.mem_done), 16'h0001);
    checkOutput("st_we_low_cycles", 16'(we_low_cycles - we_snap), 16'h0001);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0008, 16'h0000);
    tick();
    checkOutput("rb_rd_addr", bus.ram_addr, 16'h0008);
    tick();
    checkOutput("rb_done", 16'(bus.mem_done), 16'h0001);
    checkOutput("rb_rdata", bus.mem_rdata, 16'h0014);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Simultaneous fetch and data read: data first, fetch right after
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0000);
    #1;
    checkOutput("cf_conflict_req", 16'(bus.mem_conflict), 16'h0001);
    tick();
    checkOutput("cf_data_addr", bus.ram_addr, 16'h0020);
    tick();
    checkOutput("cf_mem_done", 16'(bus.mem_done), 16'h0001);
    checkOutput("cf_mem_rdata", bus.mem_rdata, 16'hBEEF);
    checkOutput("cf_if_done_early", 16'(bus.if_done), 16'h0000);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    checkOutput("cf_conflict_clear", 16'(bus.mem_conflict), 16'h0000);
    tick();
    checkOutput("cf_fetch_addr", bus.ram_addr, 16'h0010);
    tick();
    checkOutput("cf_if_done", 16'(bus.if_done), 16'h0001);
    checkOutput("cf_if_inst", bus.if_inst, 16'h1234);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Alternating write/read stream, OE and WE never low together
    both_snap = both_low_cycles;
    doAccess("alt_w0", 1'b1, 16'h0030, 16'hA5A5, 16'h0000);
    doAccess("alt_r0", 1'b0, 16'h0030, 16'h0000, 16'hA5A5);
    doAccess("alt_w1", 1'b1, 16'h0031, 16'h5A5A, 16'h0000);
    doAccess("alt_r1", 1'b0, 16'h0031, 16'h0000, 16'h5A5A);
    doAccess("alt_r2", 1'b0, 16'h0030, 16'h0000, 16'hA5A5);
    checkOutput("alt_both_low", 16'(both_low_cycles - both_snap), 16'h0000);

    // Starvation: data read held continuously while a fetch waits
    data_count         = 0;
    fetch_seen         = 0;
    conflict_at_fourth = 1'bx;
    applyStimulus(1'b1, 16'h0004, 1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.mem_done) begin
        data_count++;
        if (data_count == 4) conflict_at_fourth = bus.mem_conflict;
      end
      if (bus.if_done) begin
        fetch_seen = 1;
        break;
      end
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    checkOutput("stv_fetch_seen", 16'(fetch_seen), 16'h0001);
    checkOutput("stv_data_before_fetch", 16'(data_count), 16'h0004);
    checkOutput("stv_conflict_forced", 16'(conflict_at_fourth), 16'h0000);
    checkOutput("stv_if_inst", bus.if_inst, 16'h4A05);
`else
    checkOutput("stv_fetch_seen", 16'(fetch_seen), 16'h0000);
    checkOutput("stv_data_served", 16'(data_count >= 10), 16'h0001);
    checkOutput("stv_conflict_strict", 16'(conflict_at_fourth), 16'h0001);
`endif
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) tick();

    // Reset asserted during the write pulse aborts the write
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'h7777);
    tick();
    tick();
    checkOutput("rw_pulse_we", 16'(bus.ram_we_n), 16'h0000);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rw_strobes", 16'({bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n}), 16'h0007);
    checkOutput("rw_ram_addr", bus.ram_addr, 16'h0000);
    checkOutput("rw_ram_wdata", bus.ram_wdata, 16'h0000);
    checkOutput("rw_mem_done", 16'(bus.mem_done), 16'h0000);
    checkOutput("rw_if_inst", bus.if_inst, 16'h0000);
    checkOutput("rw_mem_rdata", bus.mem_rdata, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    checkOutput("rw_held_done", 16'(bus.mem_done), 16'h0000);
    rst = 1'b1;
    tick();
    checkOutput("rw_after_done", 16'(bus.mem_done), 16'h0000);
    checkOutput("rw_after_strobes", 16'({bus.ram_en_n, bus.ram_oe_n, bus.ram_we_n}), 16'h0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
